// File: rtl/multi_acc.sv
// multi_acc: sums partial products over each multiplier busy interval, saturates to 16 bits, optional ReLU, valid/ready result
module multi_acc #(
    parameter int ACC_W = 24,
    parameter int OUT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_vld,
    input  logic [OUT_W-1:0] in_data,
    input  logic             multi_busy,
    input  logic             acc_clr,
    input  logic             relu_en,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic [OUT_W-1:0] out_data,
    output logic             acc_busy,
    output logic             ovf_err
);
    typedef enum logic [1:0] {IDLE, ACCUM, FLUSH} state_t;
    state_t           state;
    logic [ACC_W-1:0] acc, in_ext;
    logic [OUT_W-1:0] sat, res;
    logic             grp_end, reg_free, fits, load;
    assign in_ext   = {{(ACC_W-OUT_W){in_data[OUT_W-1]}}, in_data};
    assign grp_end  = ~multi_busy & ~in_vld;
    assign reg_free = ~out_vld | out_rdy;
    assign fits     = &acc[ACC_W-1:OUT_W-1] | ~|acc[ACC_W-1:OUT_W-1];
    assign sat      = fits ? acc[OUT_W-1:0] : {acc[ACC_W-1], {(OUT_W-1){~acc[ACC_W-1]}}};
    assign res      = relu_en & sat[OUT_W-1] ? '0 : sat;
    assign load     = (state == ACCUM & grp_end | state == FLUSH) & reg_free;
    assign acc_busy = state != IDLE | out_vld;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state    <= IDLE;
            acc      <= '0;
            out_vld  <= 1'b0;
            out_data <= '0;
            ovf_err  <= 1'b0;
        end else if (acc_clr) begin
            state    <= IDLE;
            acc      <= '0;
            out_vld  <= 1'b0;
            out_data <= '0;
            ovf_err  <= 1'b0;
        end else begin
            if (load) begin
                out_vld  <= 1'b1;
                out_data <= res;
            end else if (out_rdy)
                out_vld <= 1'b0;
            if (state == FLUSH & in_vld)
                ovf_err <= 1'b1;
            if (load) begin
                acc   <= '0;
                state <= IDLE;
            end else if (state == IDLE & (in_vld | multi_busy)) begin
                acc   <= in_vld ? in_ext : '0;
                state <= ACCUM;
            end else if (state == ACCUM & in_vld)
                acc <= acc + in_ext;
            else if (state == ACCUM & grp_end)
                state <= FLUSH;
        end
endmodule
